ex_mem_stage: RTL
=================

# ex_mem_stage

Parametrised EX/MEM pipeline stage register with valid/ready flow control, flush, and an optional skid entry. It sits between the execute and memory stages and carries the WB/M control fields, the ALU result, the store data and the destination register. It holds data under back-pressure and converts flushed or empty slots into control-zero bubbles. A saturating stall counter supports performance debugging.

## Interface
- WB_W, 2: width of WB control field
- M_W, 2: width of M control field
- DATA_W, 32: width of ALU result and write data
- REG_W, 5: width of destination register index
- SKID, 1: 1 = two-entry (main + skid) buffer with registered ready_o; 0 = single entry with combinational ready_o
- CNT_W, 16: stall counter width

Ports:
- clk_i  in  1  clock; all state updates on falling edge of clk_i
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  upstream entry present
- ready_o  out  1  stage can accept this cycle
- flush_i  in  1  kill all held entries and the incoming entry
- WB_i  in  WB_W, M_i  in  M_W, ALUresult_i  in  DATA_W, WriteData_i  in  DATA_W, RegDst_i  in  REG_W: payload
- valid_o  out  1  output entry present
- ready_i  in  1  downstream accepts
- WB_o  out  WB_W, M_o  out  M_W, ALUresult_o  out  DATA_W, WriteData_o  out  DATA_W, RegDst_o  out  REG_W: payload of main entry
- stall_cnt_o  out  CNT_W  edges spent with valid_o=1 and ready_i=0

## Operation
- Accept = valid_i & ready_o at an edge.
- Deliver = valid_o & ready_i at an edge.
- SKID=1 uses three states, encoded by main valid and skid valid:
  - EMPTY: accept -> ONE, payload loaded into main.
  - ONE: accept & deliver -> ONE, main reloaded. Accept & !deliver -> FULL, payload loaded into skid. !accept & deliver -> EMPTY. Otherwise hold.
  - FULL: ready_o=0, so inputs are ignored. Deliver -> ONE, main <= skid. Otherwise hold.
  - ready_o = !skid_valid (registered).
- SKID=0:
  - ready_o = ready_i | !valid_o (combinational).
  - Accept loads main and sets valid.
  - Deliver without accept clears valid.
- flush_i=1 at an edge:
  - Main and skid valid clear, so the state becomes EMPTY.
  - The incoming entry is dropped regardless of valid_i.
  - Flush has priority over accept and deliver.
- Bubble masking: WB_o and M_o are forced to 0 whenever valid_o=0. ALUresult_o, WriteData_o and RegDst_o hold their last main-entry value.
- stall_cnt_o increments on each edge with valid_o & !ready_i & !flush_i. It saturates at 2^CNT_W-1 and is cleared only by rst_i.
- Payload fields are captured verbatim. There is no arithmetic on the payload.

## Timing
- Reset (rst_i=1 at a falling edge):
  - valid_o=0, skid empty, ready_o=1.
  - All payload outputs = 0, stall_cnt_o=0.
  - rst_i overrides flush_i, valid_i and ready_i.
  - Mid-operation reset discards all held entries; nothing is delivered.
- Latency: an entry accepted at edge N is visible on the outputs after edge N, with valid_o=1. Throughput is one entry per cycle while ready_i=1.
- With SKID=1, ready_o depends only on state and has no combinational path from ready_i. It drops the edge after the skid fills and rises the edge after the skid drains.
- Entries leave in acceptance order. No entry is duplicated or lost except by flush or reset.
- Under a stall, payload outputs are stable and unchanged until deliver.

## Test plan
- Reset, then stream three entries with ALUresult_i = 0x11, 0x22, 0x33 and ready_i=1 -> each appears on the output one edge after acceptance with valid_o=1; ready_o stays 1; stall_cnt_o=0.
- SKID=1: hold ready_i=0 with valid_i=1 and entries A=0xA, B=0xB -> A held at the output, B in skid, ready_o=0 after the second edge. Release ready_i -> outputs show A then B on consecutive edges, and ready_o returns to 1 one edge after the skid drains.
- Flush in FULL with valid_i=1 and payload 0xC -> next edge valid_o=0, WB_o=0, M_o=0, ready_o=1; 0xC never appears.
- Stall 5 edges with valid_o=1 -> stall_cnt_o=5. With CNT_W=2, stall 6 edges -> stall_cnt_o=3 (saturated).
- Assert rst_i mid-stall, with a held entry and stall_cnt_o=4 -> next edge all outputs 0, ready_o=1, held entries never delivered.
- SKID=0: ready_i toggles every cycle with continuous valid_i -> ready_o follows ready_i | !valid_o combinationally, with no loss and no duplication over 8 entries.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register carrying WB/M control, ALU result, store data and destination register.
// Latency: an entry accepted at a falling edge appears on the outputs right after that edge.
// Backpressure: SKID=1 gives a main+skid buffer with registered ready_o; SKID=0 gives a single entry with combinational ready_o.
module ex_mem_stage #(
  parameter int WB_W   = 2,
  parameter int M_W    = 2,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  input  logic [WB_W-1:0]   WB_i,
  input  logic [M_W-1:0]    M_i,
  input  logic [DATA_W-1:0] ALUresult_i,
  input  logic [DATA_W-1:0] WriteData_i,
  input  logic [REG_W-1:0]  RegDst_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WB_W-1:0]   WB_o,
  output logic [M_W-1:0]    M_o,
  output logic [DATA_W-1:0] ALUresult_o,
  output logic [DATA_W-1:0] WriteData_o,
  output logic [REG_W-1:0]  RegDst_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdat;
    logic [REG_W-1:0]  rd;
  } ent_t;

  ent_t             r_main;
  ent_t             r_skid;
  logic             r_main_vld;
  logic             r_skid_vld;
  logic [CNT_W-1:0] r_stall_cnt;

  ent_t w_in;
  logic w_ready;
  logic w_accept;
  logic w_deliver;

  assign w_in.wb   = WB_i;
  assign w_in.m    = M_i;
  assign w_in.alu  = ALUresult_i;
  assign w_in.wdat = WriteData_i;
  assign w_in.rd   = RegDst_i;

  // With a skid entry, ready depends only on state; without it, a draining main entry frees the slot.
  assign w_ready   = (SKID != 0) ? !r_skid_vld : (ready_i | !r_main_vld);
  assign w_accept  = valid_i & w_ready;
  assign w_deliver = r_main_vld & ready_i;

  // Entry storage: state is {main valid, skid valid}; flush empties both and drops the incoming entry.
  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (flush_i) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (SKID != 0) begin
      case ({r_main_vld, r_skid_vld})
        2'b00: begin
          if (w_accept) begin
            r_main     <= w_in;
            r_main_vld <= 1'b1;
          end
        end
        2'b10: begin
          if (w_accept && w_deliver) begin
            r_main <= w_in;
          end else if (w_accept) begin
            r_skid     <= w_in;
            r_skid_vld <= 1'b1;
          end else if (w_deliver) begin
            r_main_vld <= 1'b0;
          end
        end
        2'b11: begin
          if (w_deliver) begin
            r_main     <= r_skid;
            r_skid_vld <= 1'b0;
          end
        end
        default: begin
          // Skid without main cannot arise; fall back to empty.
          r_skid_vld <= 1'b0;
        end
      endcase
    end else begin
      if (w_accept) begin
        r_main     <= w_in;
        r_main_vld <= 1'b1;
      end else if (w_deliver) begin
        r_main_vld <= 1'b0;
      end
    end
  end

  // Saturating count of edges where a valid output was held back by downstream.
  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (r_main_vld && !ready_i && !flush_i && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Control fields read as zero in bubbles so downstream never acts on a stale entry.
  assign ready_o     = w_ready;
  assign valid_o     = r_main_vld;
  assign WB_o        = r_main_vld ? r_main.wb : '0;
  assign M_o         = r_main_vld ? r_main.m  : '0;
  assign ALUresult_o = r_main.alu;
  assign WriteData_o = r_main.wdat;
  assign RegDst_o    = r_main.rd;
  assign stall_cnt_o = r_stall_cnt;

endmodule
